in_cond5: RTL

- Five-input conditioner that sits directly upstream of the lab's 5-input NAND decode gate and drives that gate's I0..I4 pins.
- Each raw asynchronous input (switch, button, external pin) passes through a multi-flop synchronizer and a per-bit debounce counter.
- Outputs are a stable registered 5-bit vector, a one-cycle change strobe and a busy flag.
- Prevents glitches and metastability from reaching the combinational decode stage.

---
 rtl/in_cond5_pkg.sv | 14 +
 rtl/in_cond_bit.sv | 60 ++++++
 rtl/in_cond5.sv | 49 ++++
 3 files changed

// File: rtl/in_cond5_pkg.sv
// Shared constants and helpers for the five-input conditioner that feeds the
// downstream NAND decode gate.
package in_cond5_pkg;

    localparam int NUM_IN              = 5;
    localparam int SYNC_STAGES_DEF     = 2;
    localparam int DEBOUNCE_CYCLES_DEF = 4;

    // Debounce counter width; it counts up to cycles-1, so a single bit is the floor.
    function automatic int cnt_width(input int cycles);
        return (cycles <= 2) ? 1 : $clog2(cycles);
    endfunction

endpackage

// File: rtl/in_cond_bit.sv
// One conditioned input: a free-running synchronizer followed by a debounce
// counter that lets Q follow the synced bit only after it has differed long enough.
module in_cond_bit
    import in_cond5_pkg::*;
#(
    parameter int   SYNC_STAGES     = SYNC_STAGES_DEF,
    parameter int   DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter logic INIT            = 1'b0
) (
    input  logic C,
    input  logic CLR_N,
    input  logic CE,
    input  logic D,
    output logic Q,
    output logic CHG_BIT,
    output logic BUSY_BIT
);

    localparam int              CW   = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]   TERM = CW'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync;
    logic [CW-1:0]          cnt;
    logic                   s;
    logic                   differ;
    logic                   terminal;

    assign s        = sync[SYNC_STAGES-1];
    assign differ   = (s != Q);
    assign terminal = (cnt == TERM);

    // High exactly on the edge where Q will flip; the top registers it into CHG.
    assign CHG_BIT  = CE & differ & terminal;
    assign BUSY_BIT = (cnt != '0);

    always_ff @(posedge C or negedge CLR_N) begin
        if (!CLR_N) begin
            sync <= '0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], D};
        end
    end

    always_ff @(posedge C or negedge CLR_N) begin
        if (!CLR_N) begin
            cnt <= '0;
            Q   <= INIT;
        end else if (CE) begin
            if (!differ) begin
                cnt <= '0;
            end else if (terminal) begin
                Q   <= s;
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/in_cond5.sv
// Five-input conditioner driving the NAND decode gate's I0..I4: per-bit
// synchronize and debounce, plus a registered change strobe and a busy flag.
module in_cond5
    import in_cond5_pkg::*;
#(
    parameter int                SYNC_STAGES     = SYNC_STAGES_DEF,
    parameter int                DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter logic [NUM_IN-1:0] INIT            = '0
) (
    input  logic              C,
    input  logic              CLR_N,
    input  logic              CE,
    input  logic [NUM_IN-1:0] D,
    output logic [NUM_IN-1:0] Q,
    output logic              CHG,
    output logic              BUSY
);

    logic [NUM_IN-1:0] chg_bit;
    logic [NUM_IN-1:0] busy_bit;

    for (genvar k = 0; k < NUM_IN; k++) begin : g_bit
        in_cond_bit #(
            .SYNC_STAGES    (SYNC_STAGES),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .INIT           (INIT[k])
        ) u_bit (
            .C       (C),
            .CLR_N   (CLR_N),
            .CE      (CE),
            .D       (D[k]),
            .Q       (Q[k]),
            .CHG_BIT (chg_bit[k]),
            .BUSY_BIT(busy_bit[k])
        );
    end

    // chg_bit is already gated by CE, so a CE-low edge clears the strobe.
    always_ff @(posedge C or negedge CLR_N) begin
        if (!CLR_N) begin
            CHG <= 1'b0;
        end else begin
            CHG <= |chg_bit;
        end
    end

    assign BUSY = |busy_bit;

endmodule
